id_ex_stage: RTL and testbench

- Pipeline register between decode/register-read and the execute units (R-type ALU and siblings).
- Captures the instruction, PC and source operands with a valid/ready handshake; supports stall, flush and bubble insertion.
- Keeps operands of a stalled instruction coherent by snooping the writeback port (hold-patch forwarding).
- Builds op2 from a sign-extended immediate for OP-IMM instructions.

---
 rtl/id_ex_stage_pkg.sv | 19 +
 rtl/id_ex_stage_if.sv | 35 +++
 rtl/id_ex_stage_operand_build.sv | 52 +++++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared opcodes and constants for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam logic [6:0]  INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0]  INST_TYPE_I   = 7'b0010011;
    localparam logic [4:0]  ZERO          = 5'd0;
    localparam logic [31:0] NOP_INST_DEF  = 32'h00000013;
    localparam int          DATA_WIDTH    = 32;
    localparam int          RDATA_WIDTH   = 32;

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, execute-side and writeback-snoop signals of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_rdata_i;
    logic [XLEN-1:0] rs2_rdata_i;
    logic            flush_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_wdata_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;

    // The stage itself.
    modport slave (
        input  in_valid_i, inst_i, pc_i, rs1_rdata_i, rs2_rdata_i,
        input  flush_i, wb_we_i, wb_rd_i, wb_wdata_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, pc_o, op1_o, op2_o
    );

    // Decode/execute environment driving the stage.
    modport master (
        output in_valid_i, inst_i, pc_i, rs1_rdata_i, rs2_rdata_i,
        output flush_i, wb_we_i, wb_rd_i, wb_wdata_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, pc_o, op1_o, op2_o
    );
endinterface

// File: rtl/id_ex_stage_operand_build.sv
// Combinational operand builder: x0 zeroing, OP-IMM immediate, writeback bypass.
module id_ex_operand_build
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic            op1_fwd_o,
    output logic            op2_fwd_o
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_op1_reg;
    logic       w_op2_reg;

    assign w_opcode  = inst_i[6:0];
    assign w_rs1     = rs1_of(inst_i);
    assign w_rs2     = rs2_of(inst_i);

    // Register-sourced means a non-x0 register feeds the operand; x0 is never forwarded.
    assign w_op1_reg = (w_rs1 != ZERO);
    assign w_op2_reg = (w_opcode != INST_TYPE_I) && (w_rs2 != ZERO);

    assign op1_fwd_o = w_op1_reg && wb_we_i && (wb_rd_i == w_rs1);
    assign op2_fwd_o = w_op2_reg && wb_we_i && (wb_rd_i == w_rs2);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        op1_o = '0;
        op2_o = rs2_data_i;
        if (op1_fwd_o) begin
            op1_o = wb_wdata_i;
        end else if (w_op1_reg) begin
            op1_o = rs1_data_i;
        end
        case (w_opcode)
            INST_TYPE_I:   op2_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
            INST_TYPE_R_M: op2_o = op2_fwd_o ? wb_wdata_i : (w_op2_reg ? rs2_data_i : '0);
            default:       op2_o = op2_fwd_o ? wb_wdata_i : rs2_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and writeback hold-patch.
// Optional two-entry skid buffer enabled by defining ID_EX_SKID_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } entry_t;

    entry_t          r_main;
    entry_t          w_empty;
    entry_t          w_cap;
    entry_t          w_main_held;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_retire;
    logic [XLEN-1:0] w_cap_op1;
    logic [XLEN-1:0] w_cap_op2;
    logic [1:0]      w_cap_fwd_unused;
    logic [XLEN-1:0] w_m_op1;
    logic [XLEN-1:0] w_m_op2;
    logic            w_m_fwd1;
    logic            w_m_fwd2;

    assign w_empty  = '{valid: 1'b0, inst: NOP_INST, pc: '0, op1: '0, op2: '0};
    assign w_cap    = '{valid: 1'b1, inst: bus.inst_i, pc: bus.pc_i, op1: w_cap_op1, op2: w_cap_op2};
    assign w_accept = bus.in_valid_i && w_in_ready;
    assign w_retire = r_main.valid && bus.out_ready_i;

    id_ex_operand_build #(.XLEN(XLEN)) u_cap_build (
        .inst_i     (bus.inst_i),
        .rs1_data_i (bus.rs1_rdata_i),
        .rs2_data_i (bus.rs2_rdata_i),
        .wb_we_i    (bus.wb_we_i),
        .wb_rd_i    (bus.wb_rd_i),
        .wb_wdata_i (bus.wb_wdata_i),
        .op1_o      (w_cap_op1),
        .op2_o      (w_cap_op2),
        .op1_fwd_o  (w_cap_fwd_unused[0]),
        .op2_fwd_o  (w_cap_fwd_unused[1])
    );

    // Held operands are fed back as "regfile data" so the builder qualifies the snoop hit.
    id_ex_operand_build #(.XLEN(XLEN)) u_main_patch (
        .inst_i     (r_main.inst),
        .rs1_data_i (r_main.op1),
        .rs2_data_i (r_main.op2),
        .wb_we_i    (bus.wb_we_i),
        .wb_rd_i    (bus.wb_rd_i),
        .wb_wdata_i (bus.wb_wdata_i),
        .op1_o      (w_m_op1),
        .op2_o      (w_m_op2),
        .op1_fwd_o  (w_m_fwd1),
        .op2_fwd_o  (w_m_fwd2)
    );

    always_comb begin
        w_main_held = r_main;
        if (w_m_fwd1) w_main_held.op1 = w_m_op1;
        if (w_m_fwd2) w_main_held.op2 = w_m_op2;
    end

`ifdef ID_EX_SKID_EN
    entry_t          r_skid;
    entry_t          w_skid_held;
    logic [XLEN-1:0] w_s_op1;
    logic [XLEN-1:0] w_s_op2;
    logic            w_s_fwd1;
    logic            w_s_fwd2;

    id_ex_operand_build #(.XLEN(XLEN)) u_skid_patch (
        .inst_i     (r_skid.inst),
        .rs1_data_i (r_skid.op1),
        .rs2_data_i (r_skid.op2),
        .wb_we_i    (bus.wb_we_i),
        .wb_rd_i    (bus.wb_rd_i),
        .wb_wdata_i (bus.wb_wdata_i),
        .op1_o      (w_s_op1),
        .op2_o      (w_s_op2),
        .op1_fwd_o  (w_s_fwd1),
        .op2_fwd_o  (w_s_fwd2)
    );

    always_comb begin
        w_skid_held = r_skid;
        if (w_s_fwd1) w_skid_held.op1 = w_s_op1;
        if (w_s_fwd2) w_skid_held.op2 = w_s_op2;
    end

    assign w_in_ready = !r_skid.valid;

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i || bus.flush_i) begin
            r_main <= w_empty;
            r_skid <= w_empty;
        end else if (!r_main.valid || w_retire) begin
            // Main slot frees up: the older skid entry goes first to keep order.
            if (r_skid.valid) begin
                r_main <= w_skid_held;
            end else begin
                r_main <= w_accept ? w_cap : w_empty;
            end
            r_skid <= w_empty;
        end else begin
            r_main <= w_main_held;
            if (r_skid.valid) begin
                r_skid <= w_skid_held;
            end else begin
                r_skid <= w_accept ? w_cap : w_empty;
            end
        end
    end
`else
    assign w_in_ready = !r_main.valid || bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i || bus.flush_i) begin
            r_main <= w_empty;
        end else if (w_accept) begin
            r_main <= w_cap;
        end else if (w_retire) begin
            r_main <= w_empty;
        end else begin
            r_main <= w_main_held;
        end
    end
`endif

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_main.valid;
    assign bus.inst_o      = r_main.inst;
    assign bus.pc_o        = r_main.pc;
    assign bus.op1_o       = r_main.op1;
    assign bus.op2_o       = r_main.op2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector table plus hand-written stall, patch, flush, stream and reset sequences.
module tb_id_ex_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .NOP_INST(NOP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid_i  = v;
        bus.inst_i      = inst;
        bus.pc_i        = pc;
        bus.rs1_rdata_i = rs1;
        bus.rs2_rdata_i = rs2;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bus.wb_we_i    = we;
        bus.wb_rd_i    = rd;
        bus.wb_wdata_i = wd;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd0);
        check({tag, "_inst"},  bus.inst_o, NOP);
        check({tag, "_pc"},    bus.pc_o,   32'd0);
        check({tag, "_op1"},   bus.op1_o,  32'd0);
        check({tag, "_op2"},   bus.op2_o,  32'd0);
        check({tag, "_ready"}, {31'd0, bus.in_ready_o}, 32'd1);
    endtask

    vec_t vecs [11];

    initial begin
        int k;
        int r;
        int extra;
        logic acc;
        logic ret;

        n_checks = 0;
        n_fail   = 0;

        // add x3,x1,x2 / addi x5,x1,-1 / x0 zeroing / bypass / immediate not bypassed / store / rs1==rs2
        vecs[0]  = '{32'h002081B3, 32'h100, 32'd5,    32'd7,    1'b0, 5'd0, 32'h0,    32'd5,    32'd7};
        vecs[1]  = '{32'hFFF08293, 32'h104, 32'd10,   32'h1234, 1'b0, 5'd0, 32'h0,    32'd10,   32'hFFFFFFFF};
        vecs[2]  = '{32'h002001B3, 32'h108, 32'h55,   32'd7,    1'b0, 5'd0, 32'h0,    32'd0,    32'd7};
        vecs[3]  = '{32'h000081B3, 32'h10C, 32'h11,   32'h99,   1'b0, 5'd0, 32'h0,    32'h11,   32'd0};
        vecs[4]  = '{32'h002081B3, 32'h110, 32'd5,    32'd7,    1'b1, 5'd1, 32'hABC,  32'hABC,  32'd7};
        vecs[5]  = '{32'h002081B3, 32'h114, 32'd5,    32'd7,    1'b1, 5'd2, 32'h777,  32'd5,    32'h777};
        vecs[6]  = '{32'h002001B3, 32'h118, 32'h55,   32'd7,    1'b1, 5'd0, 32'hBAD,  32'd0,    32'd7};
        vecs[7]  = '{32'h00208293, 32'h11C, 32'd3,    32'h44,   1'b1, 5'd2, 32'hBEEF, 32'd3,    32'd2};
        vecs[8]  = '{32'h80008293, 32'h120, 32'd1,    32'h0,    1'b0, 5'd0, 32'h0,    32'd1,    32'hFFFFF800};
        vecs[9]  = '{32'h0020A023, 32'h124, 32'h100,  32'h77,   1'b1, 5'd2, 32'h5A5A, 32'h100,  32'h5A5A};
        vecs[10] = '{32'h004201B3, 32'h128, 32'h1,    32'h2,    1'b1, 5'd4, 32'h42,   32'h42,   32'h42};

        rst             = 1'b1;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;

        // Back-to-back table vectors with execute always ready.
        for (int i = 0; i < 11; i++) begin
            drive_in(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            drive_wb(vecs[i].we, vecs[i].rd, vecs[i].wd);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid_o}, 32'd1);
            check($sformatf("vec%0d_inst", i),  bus.inst_o, vecs[i].inst);
            check($sformatf("vec%0d_pc", i),    bus.pc_o,   vecs[i].pc);
            check($sformatf("vec%0d_op1", i),   bus.op1_o,  vecs[i].e_op1);
            check($sformatf("vec%0d_op2", i),   bus.op2_o,  vecs[i].e_op2);
        end
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        step();
        check("drain_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("drain_inst",  bus.inst_o, NOP);

        // Hold-patch while stalled.
        bus.out_ready_i = 1'b0;
        drive_in(1'b1, 32'h002081B3, 32'h200, 32'd5, 32'd7);
        step();
        check("hold_op1_init", bus.op1_o, 32'd5);
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive_wb(1'b1, 5'd1, 32'hDEAD);
        step();
        check("patch_op1",   bus.op1_o,  32'hDEAD);
        check("patch_op2",   bus.op2_o,  32'd7);
        check("patch_inst",  bus.inst_o, 32'h002081B3);
        check("patch_pc",    bus.pc_o,   32'h200);
        drive_wb(1'b1, 5'd0, 32'h1111);
        step();
        check("x0_op1", bus.op1_o, 32'hDEAD);
        check("x0_op2", bus.op2_o, 32'd7);
        drive_wb(1'b1, 5'd2, 32'hCAFE);
        step();
        check("patch_rs2_op2", bus.op2_o, 32'hCAFE);
        check("patch_rs2_op1", bus.op1_o, 32'hDEAD);
        check("stall_valid", {31'd0, bus.out_valid_o}, 32'd1);
`ifdef ID_EX_SKID_EN
        check("stall_ready", {31'd0, bus.in_ready_o}, 32'd1);
`else
        check("stall_ready", {31'd0, bus.in_ready_o}, 32'd0);
`endif
        drive_wb(1'b0, 5'd0, 32'h0);

        // Flush while holding, with a same-cycle offer that must be dropped.
        bus.flush_i = 1'b1;
        drive_in(1'b1, 32'h00100093, 32'h300, 32'h0, 32'h0);
        step();
        check("flush_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("flush_inst",  bus.inst_o, NOP);
        bus.flush_i = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check("flush_dropped", {31'd0, bus.out_valid_o}, 32'd0);

        // Held immediate is never patched even when inst[24:20] matches.
        drive_in(1'b1, 32'h00208293, 32'h400, 32'd3, 32'h0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive_wb(1'b1, 5'd2, 32'hBEEF);
        step();
        check("imm_nopatch_op2", bus.op2_o, 32'd2);
        check("imm_nopatch_op1", bus.op1_o, 32'd3);
        drive_wb(1'b0, 5'd0, 32'h0);
        bus.out_ready_i = 1'b1;
        step();
        check("retire_empty", {31'd0, bus.out_valid_o}, 32'd0);

        // Stream of 8 addi x1,x0,k+1 with execute ready toggling 1,0,1,0.
        k = 0;
        r = 0;
        for (int cyc = 0; cyc < 200 && (k < 8 || r < 8); cyc++) begin
            bus.out_ready_i = (cyc % 2 == 0);
            drive_in(k < 8, ((k + 1) << 20) | 32'h00000093, 32'h1000 + 4 * k, 32'hFFFF, 32'h0);
            #1;
            acc = bus.in_valid_i && bus.in_ready_o;
            ret = bus.out_valid_o && bus.out_ready_i;
            if (ret) begin
                check($sformatf("stream%0d_pc", r),  bus.pc_o,  32'h1000 + 4 * r);
                check($sformatf("stream%0d_op2", r), bus.op2_o, r + 1);
                check($sformatf("stream%0d_op1", r), bus.op1_o, 32'd0);
                r++;
            end
            if (acc) k++;
            step();
        end
        check("stream_retired", r, 8);
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.out_ready_i = 1'b1;
        extra = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (bus.out_valid_o) extra++;
            step();
        end
        check("stream_no_dup", extra, 0);

        // Reset mid-stall overrides flush and a pending offer.
        bus.out_ready_i = 1'b0;
        drive_in(1'b1, 32'h002081B3, 32'h500, 32'd9, 32'd8);
        step();
        check("pre_reset_valid", {31'd0, bus.out_valid_o}, 32'd1);
        rst         = 1'b1;
        bus.flush_i = 1'b1;
        step();
        check_reset_state("midrst");
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
